// File: rtl/tap_recorder.sv
// Tape record-side decoder: measures ear half-periods in T-states, decodes
// ZX Spectrum pilot/sync/bit encoding and writes TAP-format blocks to memory.
module tap_recorder #(
  parameter int unsigned T_DIV      = 7,
  parameter int unsigned PILOT_LO   = 1900,
  parameter int unsigned PILOT_HI   = 2500,
  parameter int unsigned PILOT_MIN  = 256,
  parameter int unsigned SYNC_MAX   = 1000,
  parameter int unsigned BIT_THRESH = 2565,
  parameter int unsigned END_T      = 3500
) (
  input  logic        clock,
  input  logic        reset,
  input  logic        ear,
  input  logic        rec,
  output logic [15:0] tap_address,
  output logic [7:0]  tap_data,
  output logic        tap_we,
  output logic        block_done,
  output logic        chk_ok,
  output logic        busy
);

  localparam int unsigned PW  = (T_DIV > 1) ? $clog2(T_DIV) : 1;
  localparam int unsigned HW  = 12;
  localparam int unsigned PCW = 10;

  localparam logic [PW-1:0]  PRE_LAST   = PW'(T_DIV - 1);
  localparam logic [HW-1:0]  PILOT_LO_H = HW'(PILOT_LO);
  localparam logic [HW-1:0]  PILOT_HI_H = HW'(PILOT_HI);
  localparam logic [HW-1:0]  SYNC_H     = HW'(SYNC_MAX);
  localparam logic [HW-1:0]  END_H      = HW'(END_T);
  localparam logic [PCW-1:0] PMIN_P     = PCW'(PILOT_MIN);
  localparam logic [HW:0]    THRESH_S   = (HW + 1)'(BIT_THRESH);

  typedef enum logic [2:0] {
    S_IDLE, S_PILOT, S_SYNC2, S_DATA_A, S_DATA_B, S_LEN_LO, S_LEN_HI, S_DONE
  } state_t;

  state_t          state_q, state_d;
  logic            ear_s1_q, ear_s2_q, ear_s3_q;
  logic [PW-1:0]   pre_q, pre_d;
  logic [HW-1:0]   hc_q, hc_d;
  logic [HW-1:0]   h1_q, h1_d;
  logic [PCW-1:0]  pc_q, pc_d;
  logic [6:0]      sr_q, sr_d;
  logic [2:0]      bc_q, bc_d;
  logic [15:0]     len_q, len_d;
  logic [7:0]      xr_q, xr_d;
  logic [15:0]     ptr_q, ptr_d;
  logic [15:0]     addr_q, addr_d;
  logic [7:0]      data_q, data_d;
  logic            we_q, we_d;
  logic            done_q, done_d;
  logic            chk_q, chk_d;
  logic            busy_q, busy_d;

  logic            tick_c, edge_c, tout_c, pilot_c, sync_c, bit_c;
  logic [HW:0]     sum_c;
  logic [7:0]      byte_c;

  assign tick_c  = (pre_q == PRE_LAST);
  assign edge_c  = ear_s2_q ^ ear_s3_q;
  assign tout_c  = !edge_c && (hc_q == END_H);
  assign pilot_c = (hc_q >= PILOT_LO_H) && (hc_q <= PILOT_HI_H);
  assign sync_c  = (hc_q < SYNC_H);
  assign sum_c   = (HW + 1)'(h1_q) + (HW + 1)'(hc_q);
  assign bit_c   = (sum_c >= THRESH_S);
  assign byte_c  = {sr_q, bit_c};

  // T-state prescaler and saturating half-period counter; an edge restarts it
  always_comb begin
    pre_d = tick_c ? '0 : pre_q + PW'(1);
    hc_d  = hc_q;
    if (edge_c)
      hc_d = '0;
    else if (tick_c && (hc_q != '1))
      hc_d = hc_q + HW'(1);
  end

  always_comb begin
    state_d = state_q;
    pc_d    = pc_q;
    h1_d    = h1_q;
    sr_d    = sr_q;
    bc_d    = bc_q;
    len_d   = len_q;
    xr_d    = xr_q;
    ptr_d   = ptr_q;
    addr_d  = addr_q;
    data_d  = data_q;
    we_d    = 1'b0;
    done_d  = 1'b0;
    chk_d   = chk_q;
    if (!rec) begin
      state_d = S_IDLE;
    end else begin
      case (state_q)
        S_IDLE: begin
          if (edge_c && pilot_c) begin
            state_d = S_PILOT;
            pc_d    = PCW'(1);
          end
        end
        S_PILOT: begin
          if (edge_c) begin
            if (pilot_c) begin
              if (pc_q != '1) pc_d = pc_q + PCW'(1);
            end else if (sync_c && (pc_q >= PMIN_P)) begin
              state_d = S_SYNC2;
            end else begin
              state_d = S_IDLE;
            end
          end else if (tout_c) begin
            state_d = S_IDLE;
          end
        end
        S_SYNC2: begin
          if (edge_c) begin
            if (sync_c) begin
              state_d = S_DATA_A;
              len_d   = '0;
              bc_d    = '0;
              xr_d    = '0;
            end else begin
              state_d = S_IDLE;
            end
          end else if (tout_c) begin
            state_d = S_IDLE;
          end
        end
        S_DATA_A, S_DATA_B: begin
          if (edge_c) begin
            if (state_q == S_DATA_A) begin
              h1_d    = hc_q;
              state_d = S_DATA_B;
            end else begin
              sr_d    = byte_c[6:0];
              bc_d    = bc_q + 3'd1;
              state_d = S_DATA_A;
              if (bc_q == 3'd7) begin
                we_d   = 1'b1;
                addr_d = ptr_q + 16'd2 + len_q;
                data_d = byte_c;
                len_d  = len_q + 16'd1;
                xr_d   = xr_q ^ byte_c;
              end
            end
          end else if (tout_c) begin
            // A partial byte is simply dropped; an empty block commits nothing
            if (len_q != '0) begin
              state_d = S_LEN_LO;
              we_d    = 1'b1;
              addr_d  = ptr_q;
              data_d  = len_q[7:0];
            end else begin
              state_d = S_IDLE;
            end
          end
        end
        S_LEN_LO: begin
          state_d = S_LEN_HI;
          we_d    = 1'b1;
          addr_d  = ptr_q + 16'd1;
          data_d  = len_q[15:8];
        end
        S_LEN_HI: begin
          state_d = S_DONE;
          done_d  = 1'b1;
          chk_d   = (xr_q == 8'd0);
        end
        S_DONE: begin
          state_d = S_IDLE;
          ptr_d   = ptr_q + 16'd2 + len_q;
        end
        default: state_d = S_IDLE;
      endcase
    end
    busy_d = (state_d != S_IDLE);
  end

  always_ff @(posedge clock) begin
    if (reset) begin
      state_q  <= S_IDLE;
      ear_s1_q <= 1'b0;
      ear_s2_q <= 1'b0;
      ear_s3_q <= 1'b0;
      pre_q    <= '0;
      hc_q     <= '0;
      h1_q     <= '0;
      pc_q     <= '0;
      sr_q     <= '0;
      bc_q     <= '0;
      len_q    <= '0;
      xr_q     <= '0;
      ptr_q    <= '0;
      addr_q   <= '0;
      data_q   <= '0;
      we_q     <= 1'b0;
      done_q   <= 1'b0;
      chk_q    <= 1'b0;
      busy_q   <= 1'b0;
    end else begin
      state_q  <= state_d;
      ear_s1_q <= ear;
      ear_s2_q <= ear_s1_q;
      ear_s3_q <= ear_s2_q;
      pre_q    <= pre_d;
      hc_q     <= hc_d;
      h1_q     <= h1_d;
      pc_q     <= pc_d;
      sr_q     <= sr_d;
      bc_q     <= bc_d;
      len_q    <= len_d;
      xr_q     <= xr_d;
      ptr_q    <= ptr_d;
      addr_q   <= addr_d;
      data_q   <= data_d;
      we_q     <= we_d;
      done_q   <= done_d;
      chk_q    <= chk_d;
      busy_q   <= busy_d;
    end
  end

  assign tap_address = addr_q;
  assign tap_data    = data_q;
  assign tap_we      = we_q;
  assign block_done  = done_q;
  assign chk_ok      = chk_q;
  assign busy        = busy_q;

endmodule
